level_sequencer: RTL and testbench
==================================

LEVEL_SEQUENCER -- requirements
Module: level_sequencer

Interface
REQ-001 Parameter NUM_LEVELS, default 3, number of playable levels (>=2).
REQ-002 Parameter LIVES, default 3, lives granted at game start (1..15).
REQ-003 Parameter SCORE_W, default 16, score accumulator width.
REQ-004 Parameter TRANSITION_CYCLES, default 4, cycles level_reset is held between levels (>=1).
REQ-005 Parameter LW = $clog2(NUM_LEVELS+1), derived, width of level and select outputs.
REQ-006 Clk  input  1  single system clock; all state updates on its rising edge.
REQ-007 Reset  input  1  synchronous, active-low reset; sampled on the rising edge of Clk.
REQ-008 start  input  1  level-sensitive start/continue request (fire button); the block acts only on its rising edge.
REQ-009 is_won_lev  input  NUM_LEVELS  per-level win flag; bit i high means level i is cleared.
REQ-010 is_lost_lev  input  NUM_LEVELS  per-level loss flag; bit i high means the player died in level i.
REQ-011 score_inc  input  1  one-cycle score event from the active level.
REQ-012 score_amt  input  8  points added per score_inc event.
REQ-013 level  output  LW  index of the active level, 0..NUM_LEVELS-1.
REQ-014 level_reset  output  1  active-high reset to all level instances.
REQ-015 mapper_select  output  LW  colour-mapper mux select; the value NUM_LEVELS selects the title/end screen.
REQ-016 lives  output  4  remaining lives.
REQ-017 score  output  SCORE_W  accumulated score.
REQ-018 game_won  output  1  high in END after the final level is cleared.
REQ-019 game_lost  output  1  high in END after the last life is lost.

Function
REQ-020 The FSM SHALL have the states IDLE, XFER, PLAY and END.
REQ-021 Start edge SHALL be detected as start=1 with the previous-cycle start=0, using a registered copy of start.
REQ-022 IDLE: mapper_select=NUM_LEVELS, level_reset=1, level=0. On a start edge the block SHALL load lives=LIVES, clear score to 0, load cnt=TRANSITION_CYCLES-1 and go to XFER.
REQ-023 XFER: level_reset=1, mapper_select=level, cnt decrements by 1 each cycle, and the FSM SHALL go to PLAY in the cycle after cnt reaches 0, so level_reset is high for exactly TRANSITION_CYCLES cycles.
REQ-024 PLAY: level_reset=0, mapper_select=level; only bit [level] of is_won_lev and is_lost_lev SHALL be examined.
REQ-025 PLAY with is_lost_lev[level]=1 and lives>1: lives decrements by 1, level is unchanged, cnt is reloaded, and the FSM goes to XFER (the level is retried).
REQ-026 PLAY with is_lost_lev[level]=1 and lives==1: lives goes to 0, game_lost=1, and the FSM goes to END.
REQ-027 PLAY with is_won_lev[level]=1 and level<NUM_LEVELS-1: level increments by 1, cnt is reloaded, and the FSM goes to XFER.
REQ-028 PLAY with is_won_lev[level]=1 and level==NUM_LEVELS-1: game_won=1 and the FSM goes to END.
REQ-029 When won and lost are both asserted in the same PLAY cycle, loss SHALL take priority.
REQ-030 score SHALL add score_amt (zero-extended) on each score_inc cycle in PLAY only, saturating at 2^SCORE_W-1, with no wrap-around.
REQ-031 score_inc in PLAY SHALL still be counted in the cycle in which a win or loss transition is taken.
REQ-032 score_inc SHALL be ignored in IDLE, XFER and END.
REQ-033 END: mapper_select=NUM_LEVELS, level_reset=1; score, lives and game_won/game_lost are held. On a start edge the FSM goes to IDLE and clears game_won and game_lost.
REQ-034 All outputs SHALL be registered or decoded from registered state only, with no combinational path from any input to any output.

Reset
REQ-035 Reset=0 at a clock edge SHALL, in any state including mid-XFER, force: state=IDLE, level=0, lives=0, score=0, cnt=0, game_won=0, game_lost=0, level_reset=1, mapper_select=NUM_LEVELS, and prior-start register=1 (so a start that is held through reset does not register as an edge).

Verification (NUM_LEVELS=3, LIVES=3, TRANSITION_CYCLES=4)
REQ-036 Start edge from IDLE -> level_reset high for exactly 4 cycles, then PLAY with level=0, lives=3, score=0, mapper_select=0.
REQ-037 Win levels 0, 1 and 2 in turn with 5 score_inc pulses of amt=10 in each level -> level steps 0,1,2, then END with game_won=1, score=150, mapper_select=3.
REQ-038 Lose level 1 three times -> lives goes 3,2,1 with level held at 1 across the retries, then the third loss gives lives=0, game_lost=1 and END.
REQ-039 With SCORE_W=8, score=250 and one score_inc with amt=10 -> score=255; a further increment leaves score at 255.
REQ-040 Assert won and lost together in PLAY with lives=2 -> lives=1, level unchanged, XFER entered; also set is_won_lev[2]=1 while level=0 -> no transition.
REQ-041 Reset=0 during cycle 2 of XFER with start held high -> IDLE with all outputs at reset values; releasing Reset while start is still high -> remains in IDLE until start falls and rises again.

Source files
------------

// File: rtl/level_sequencer.sv
// Game-flow controller: walks the player through NUM_LEVELS levels, holds every
// level in reset while switching, tracks lives and a saturating score.
module level_sequencer #(
    parameter int NUM_LEVELS        = 3,
    parameter int LIVES             = 3,
    parameter int SCORE_W           = 16,
    parameter int TRANSITION_CYCLES = 4,
    localparam int LW               = $clog2(NUM_LEVELS + 1)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [NUM_LEVELS-1:0] is_won_lev,
    input  logic [NUM_LEVELS-1:0] is_lost_lev,
    input  logic                  score_inc,
    input  logic [7:0]            score_amt,
    output logic [LW-1:0]         level,
    output logic                  level_reset,
    output logic [LW-1:0]         mapper_select,
    output logic [3:0]            lives,
    output logic [SCORE_W-1:0]    score,
    output logic                  game_won,
    output logic                  game_lost
);

    localparam int CNT_W = (TRANSITION_CYCLES > 1) ? $clog2(TRANSITION_CYCLES) : 1;
    localparam int SUM_W = ((SCORE_W > 8) ? SCORE_W : 8) + 1;

    localparam logic [CNT_W-1:0]   CNT_RELOAD  = CNT_W'(TRANSITION_CYCLES - 1);
    localparam logic [LW-1:0]      TITLE_SEL   = LW'(NUM_LEVELS);
    localparam logic [LW-1:0]      LAST_LEVEL  = LW'(NUM_LEVELS - 1);
    localparam logic [3:0]         LIVES_INIT  = 4'(LIVES);
    localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        PLAY = 2'd2,
        END  = 2'd3
    } state_t;

    state_t               state_q;
    logic                 start_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [LW-1:0]        level_q;
    logic [3:0]           lives_q;
    logic [SCORE_W-1:0]   score_q;
    logic                 level_reset_q;
    logic [LW-1:0]        mapper_select_q;
    logic                 won_q;
    logic                 lost_q;

    logic                 start_edge;
    logic                 cur_won;
    logic                 cur_lost;
    logic [SUM_W-1:0]     score_sum;
    logic [SCORE_W-1:0]   score_d;

    assign start_edge = start & ~start_q;
    assign cur_won    = is_won_lev[level_q];
    assign cur_lost   = is_lost_lev[level_q];

    // Widened add so the carry out of the accumulator is visible for saturation.
    always_comb begin
        score_sum = SUM_W'(score_q) + SUM_W'(score_amt);
        score_d   = score_q;
        if (score_sum > SUM_W'(SCORE_MAX)) begin
            score_d = SCORE_MAX;
        end else begin
            score_d = score_sum[SCORE_W-1:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q         <= IDLE;
            start_q         <= 1'b1;
            cnt_q           <= '0;
            level_q         <= '0;
            lives_q         <= '0;
            score_q         <= '0;
            level_reset_q   <= 1'b1;
            mapper_select_q <= TITLE_SEL;
            won_q           <= 1'b0;
            lost_q          <= 1'b0;
        end else begin
            start_q <= start;
            unique case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        lives_q         <= LIVES_INIT;
                        score_q         <= '0;
                        cnt_q           <= CNT_RELOAD;
                        mapper_select_q <= level_q;
                        state_q         <= XFER;
                    end
                end
                XFER: begin
                    if (cnt_q == '0) begin
                        level_reset_q <= 1'b0;
                        state_q       <= PLAY;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                PLAY: begin
                    if (score_inc) begin
                        score_q <= score_d;
                    end
                    // A loss outranks a simultaneous win.
                    if (cur_lost) begin
                        level_reset_q <= 1'b1;
                        if (lives_q > 4'd1) begin
                            lives_q <= lives_q - 4'd1;
                            cnt_q   <= CNT_RELOAD;
                            state_q <= XFER;
                        end else begin
                            lives_q         <= 4'd0;
                            lost_q          <= 1'b1;
                            mapper_select_q <= TITLE_SEL;
                            state_q         <= END;
                        end
                    end else if (cur_won) begin
                        level_reset_q <= 1'b1;
                        if (level_q == LAST_LEVEL) begin
                            won_q           <= 1'b1;
                            mapper_select_q <= TITLE_SEL;
                            state_q         <= END;
                        end else begin
                            level_q         <= level_q + LW'(1);
                            mapper_select_q <= level_q + LW'(1);
                            cnt_q           <= CNT_RELOAD;
                            state_q         <= XFER;
                        end
                    end
                end
                END: begin
                    if (start_edge) begin
                        won_q   <= 1'b0;
                        lost_q  <= 1'b0;
                        level_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign level         = level_q;
    assign level_reset   = level_reset_q;
    assign mapper_select = mapper_select_q;
    assign lives         = lives_q;
    assign score         = score_q;
    assign game_won      = won_q;
    assign game_lost     = lost_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Scoreboard bench for level_sequencer: stimulus queues hand-computed snapshots,
// a negedge monitor pops and compares them against two DUT instances.
module tb_level_sequencer;

    logic       clk;
    logic       Reset;
    logic       start;
    logic [2:0] wonLev;
    logic [2:0] lostLev;
    logic       scoreInc;
    logic [7:0] scoreAmt;
    logic [1:0] level;
    logic       levelReset;
    logic [1:0] mapperSelect;
    logic [3:0] lives;
    logic [15:0] score;
    logic       gameWon;
    logic       gameLost;

    logic       start1;
    logic       scoreInc1;
    logic [7:0] scoreAmt1;
    logic [2:0] zeroLev;
    logic [1:0] level1;
    logic       levelReset1;
    logic [1:0] mapperSelect1;
    logic [3:0] lives1;
    logic [7:0] score1;
    logic       gameWon1;
    logic       gameLost1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        int          kind;
        logic [1:0]  lvl;
        logic [3:0]  lives;
        logic [15:0] score;
        logic        lr;
        logic [1:0]  ms;
        logic        won;
        logic        lost;
    } exp_t;

    exp_t expQ[$];

    level_sequencer #(.NUM_LEVELS(3), .LIVES(3), .SCORE_W(16), .TRANSITION_CYCLES(4)) dut (
        .Clk(clk), .Reset(Reset), .start(start),
        .is_won_lev(wonLev), .is_lost_lev(lostLev),
        .score_inc(scoreInc), .score_amt(scoreAmt),
        .level(level), .level_reset(levelReset), .mapper_select(mapperSelect),
        .lives(lives), .score(score), .game_won(gameWon), .game_lost(gameLost)
    );

    level_sequencer #(.NUM_LEVELS(3), .LIVES(3), .SCORE_W(8), .TRANSITION_CYCLES(4)) dutSat (
        .Clk(clk), .Reset(Reset), .start(start1),
        .is_won_lev(zeroLev), .is_lost_lev(zeroLev),
        .score_inc(scoreInc1), .score_amt(scoreAmt1),
        .level(level1), .level_reset(levelReset1), .mapper_select(mapperSelect1),
        .lives(lives1), .score(score1), .game_won(gameWon1), .game_lost(gameLost1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input string name, input logic [1:0] lvl, input logic [3:0] lv,
                                 input logic [15:0] sc, input logic lr, input logic [1:0] ms,
                                 input logic won, input logic lost);
        exp_t e;
        e.name = name; e.kind = 0; e.lvl = lvl; e.lives = lv; e.score = sc;
        e.lr = lr; e.ms = ms; e.won = won; e.lost = lost;
        expQ.push_back(e);
    endtask

    task automatic applySatStimulus(input string name, input logic [15:0] sc, input logic lr);
        exp_t e;
        e.name = name; e.kind = 1; e.lvl = '0; e.lives = '0; e.score = sc;
        e.lr = lr; e.ms = '0; e.won = 1'b0; e.lost = 1'b0;
        expQ.push_back(e);
    endtask

    // Three more transition cycles, then the level comes out of reset.
    task automatic xferWait(input logic [1:0] lvl, input logic [3:0] lv, input logic [15:0] sc);
        for (int i = 0; i < 3; i++) begin
            tick();
            applyStimulus("xfer_hold", lvl, lv, sc, 1'b1, lvl, 1'b0, 1'b0);
        end
        tick();
        applyStimulus("play_entry", lvl, lv, sc, 1'b0, lvl, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (e.kind == 0) begin
            if ({level, lives, score, levelReset, mapperSelect, gameWon, gameLost} !==
                {e.lvl, e.lives, e.score, e.lr, e.ms, e.won, e.lost}) begin
                failures++;
                $display("[TB] FAIL %s: got lvl=%0d lives=%0d score=%0d lr=%0b ms=%0d won=%0b lost=%0b, want lvl=%0d lives=%0d score=%0d lr=%0b ms=%0d won=%0b lost=%0b",
                         e.name, level, lives, score, levelReset, mapperSelect, gameWon, gameLost,
                         e.lvl, e.lives, e.score, e.lr, e.ms, e.won, e.lost);
            end
        end else begin
            if ({score1, levelReset1} !== {e.score[7:0], e.lr}) begin
                failures++;
                $display("[TB] FAIL %s: got score=%0d lr=%0b, want score=%0d lr=%0b",
                         e.name, score1, levelReset1, e.score[7:0], e.lr);
            end
        end
    endtask

    // Monitor: every expectation queued after an edge is compared at the following negedge.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    initial begin
        Reset = 1'b0; start = 1'b0; wonLev = '0; lostLev = '0;
        scoreInc = 1'b0; scoreAmt = 8'd10;
        start1 = 1'b0; scoreInc1 = 1'b0; scoreAmt1 = 8'd10; zeroLev = '0;
        tick(); tick();
        applyStimulus("reset", 0, 0, 0, 1, 3, 0, 0);
        Reset = 1'b1;
        tick();
        applyStimulus("idle", 0, 0, 0, 1, 3, 0, 0);

        start = 1'b1;
        tick();
        applyStimulus("xfer_entry", 0, 3, 0, 1, 0, 0, 0);
        start = 1'b0;
        xferWait(0, 3, 0);

        wonLev = 3'b100; lostLev = 3'b100;
        tick();
        applyStimulus("other_level_bits", 0, 3, 0, 0, 0, 0, 0);
        wonLev = '0; lostLev = '0;

        for (int l = 0; l < 3; l++) begin
            scoreInc = 1'b1;
            repeat (4) tick();
            applyStimulus("score_accum", 2'(l), 3, 16'(l * 50 + 40), 0, 2'(l), 0, 0);
            wonLev = 3'b001 << l;
            tick();
            wonLev = '0;
            if (l < 2) begin
                applyStimulus("win_step", 2'(l + 1), 3, 16'(l * 50 + 50), 1, 2'(l + 1), 0, 0);
                xferWait(2'(l + 1), 3, 16'(l * 50 + 50));
            end else begin
                applyStimulus("game_won", 2, 3, 150, 1, 3, 1, 0);
            end
        end
        tick();
        applyStimulus("end_hold", 2, 3, 150, 1, 3, 1, 0);
        scoreInc = 1'b0;

        start = 1'b1;
        tick();
        applyStimulus("end_to_idle", 0, 3, 150, 1, 3, 0, 0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        applyStimulus("restart", 0, 3, 0, 1, 0, 0, 0);
        start = 1'b0;
        xferWait(0, 3, 0);
        wonLev = 3'b001;
        tick();
        wonLev = '0;
        applyStimulus("to_level1", 1, 3, 0, 1, 1, 0, 0);
        xferWait(1, 3, 0);

        lostLev = 3'b010;
        tick();
        lostLev = '0;
        applyStimulus("lose_1", 1, 2, 0, 1, 1, 0, 0);
        xferWait(1, 2, 0);
        wonLev = 3'b010; lostLev = 3'b010;
        tick();
        wonLev = '0; lostLev = '0;
        applyStimulus("lose_beats_win", 1, 1, 0, 1, 1, 0, 0);
        xferWait(1, 1, 0);
        lostLev = 3'b010;
        tick();
        lostLev = '0;
        applyStimulus("game_lost", 1, 0, 0, 1, 3, 0, 1);

        start = 1'b1;
        tick();
        applyStimulus("lost_to_idle", 0, 0, 0, 1, 3, 0, 0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        applyStimulus("xfer_c1", 0, 3, 0, 1, 0, 0, 0);
        tick();
        applyStimulus("xfer_c2", 0, 3, 0, 1, 0, 0, 0);
        Reset = 1'b0;
        tick();
        applyStimulus("mid_xfer_reset", 0, 0, 0, 1, 3, 0, 0);
        Reset = 1'b1;
        tick();
        applyStimulus("held_start_1", 0, 0, 0, 1, 3, 0, 0);
        tick();
        applyStimulus("held_start_2", 0, 0, 0, 1, 3, 0, 0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        applyStimulus("rearmed", 0, 3, 0, 1, 0, 0, 0);
        start = 1'b0;
        xferWait(0, 3, 0);

        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (4) tick();
        applySatStimulus("sat_play", 0, 0);
        scoreInc1 = 1'b1;
        repeat (25) tick();
        applySatStimulus("sat_250", 250, 0);
        tick();
        applySatStimulus("sat_255", 255, 0);
        tick();
        applySatStimulus("sat_hold", 255, 0);
        scoreInc1 = 1'b0;

        for (int i = 0; i < 5 && expQ.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (expQ.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: got %0d pending, want 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
